// File: rtl/wb_regfile.sv
// wb_regfile: architectural integer register file, written by writeback and
// read combinationally by decode. Register x0 always reads as zero.
// Optional feature macro: REGFILE_BYPASS_EN. When it is defined, a write that
// is in flight this cycle is forwarded to any read port that addresses the
// same register. When it is undefined, reads return the stored value and the
// new value becomes visible after the clock edge.
module wb_regfile #(
    parameter int WIDTH = 32,
    parameter int NREGS = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       A1,
    input  logic [4:0]       A2,
    input  logic [4:0]       A3,
    input  logic [WIDTH-1:0] WD3,
    input  logic             WE3,
    output logic [WIDTH-1:0] RD1,
    output logic [WIDTH-1:0] RD2
);

    // Stored architectural state and its next-state value.
    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];

    // A write only takes effect when it targets a real register and reset is
    // not overriding it in the same cycle.
    logic             wr_en;
    logic [NREGS-1:0] wr_sel;

    assign wr_en = WE3 && (A3 != 5'd0) && !reset;

    // One-hot write select per register; entry 0 never gets selected, which
    // keeps x0 permanently at zero without any special-casing in the flops.
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_wr_sel
            if (gi == 0) begin : g_x0
                assign wr_sel[gi] = 1'b0;
            end else begin : g_xn
                assign wr_sel[gi] = wr_en && (A3 == 5'(gi));
            end
        end
    endgenerate

    // Next-state: the selected register takes WD3, all others hold.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = wr_sel[i] ? WD3 : regs_q[i];
        end
    end

    // State register: reset clears everything and wins over any write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // The two read ports share identical logic, so they are built from a
    // small address/data array indexed by port number.
    logic [4:0]       rd_addr [2];
    logic [WIDTH-1:0] rd_data [2];

    assign rd_addr[0] = A1;
    assign rd_addr[1] = A2;
    assign RD1        = rd_data[0];
    assign RD2        = rd_data[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd_port
            // Combinational read with x0 forced to zero and optional forwarding.
            always_comb begin
                rd_data[gi] = regs_q[rd_addr[gi]];
`ifdef REGFILE_BYPASS_EN
                // wr_en already excludes A3 == 0 and reset, so x0 and the
                // reset cycle never see forwarded data.
                if (wr_en && (rd_addr[gi] == A3)) begin
                    rd_data[gi] = WD3;
                end
`endif
                if (rd_addr[gi] == 5'd0) begin
                    rd_data[gi] = '0;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed vector table, hand-written sweeps and randomized
// traffic against a simple array model of the register file.
module tb_wb_regfile;

    logic        clk;
    logic        reset;
    logic [4:0]  A1, A2, A3;
    logic [31:0] WD3;
    logic        WE3;
    logic [31:0] RD1, RD2;

    int errors = 0;
    int checks = 0;
    int txn    = 0;

    // Reference model: plain array of architectural values.
    logic [31:0] model_mem [32];

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    wb_regfile #(.WIDTH(32), .NREGS(32)) dut (
        .clk   (clk),
        .reset (reset),
        .A1    (A1),
        .A2    (A2),
        .A3    (A3),
        .WD3   (WD3),
        .WE3   (WE3),
        .RD1   (RD1),
        .RD2   (RD2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  a3;
        logic [31:0] wd;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vec_t;

    vec_t vecs [11];

    // Expected read value from the model: x0 is zero; a live write to the
    // same address is visible this cycle only in the bypass build.
    function automatic logic [31:0] model_rd(input logic [4:0] addr, input logic r,
                                             input logic w, input logic [4:0] a3v,
                                             input logic [31:0] wdv);
        if (addr == 0) return 32'h0;
        if (BYPASS && w && !r && a3v != 0 && a3v == addr) return wdv;
        return model_mem[addr];
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%08h expected=%08h", nm, got, exp);
        end
    endtask

    // Drive one cycle: apply inputs after the falling edge, check the
    // combinational outputs, then let the rising edge commit the write.
    task automatic step(input logic r, input logic w, input logic [4:0] a3v,
                        input logic [31:0] wdv, input logic [4:0] a1v,
                        input logic [4:0] a2v, input logic chk,
                        input logic [31:0] e1, input logic [31:0] e2,
                        input string nm);
        reset = r; WE3 = w; A3 = a3v; WD3 = wdv; A1 = a1v; A2 = a2v;
        #1;
        if (chk) begin
            check({nm, "_rd1"}, RD1, e1);
            check({nm, "_rd2"}, RD2, e2);
        end
        $display("txn %0d %s rst=%0b we=%0b a3=%0d wd=%08h a1=%0d rd1=%08h a2=%0d rd2=%08h",
                 txn, nm, r, w, a3v, wdv, a1v, RD1, a2v, RD2);
        txn++;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 32; i++) model_mem[i] = 32'h0;
        end else if (w && a3v != 0) begin
            model_mem[a3v] = wdv;
        end
        @(negedge clk);
    endtask

    initial begin
        logic        r, w;
        logic [4:0]  a3v, a1v, a2v;
        logic [31:0] wdv;

        reset = 1'b0; WE3 = 1'b0; A1 = '0; A2 = '0; A3 = '0; WD3 = '0;
        for (int i = 0; i < 32; i++) model_mem[i] = 32'h0;

        // Directed vectors from the test plan.
        vecs[0]  = '{1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 32'h0, 32'h0};
        vecs[1]  = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[2]  = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd6, 5'd5, 32'h0, 32'hDEADBEEF};
        vecs[3]  = '{1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 32'h0, 32'h0};
        vecs[4]  = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd0, 5'd5, 32'h0, 32'hDEADBEEF};
        vecs[5]  = '{1'b0, 1'b1, 5'd7, 32'h11111111, 5'd7, 5'd6,
                     BYPASS ? 32'h11111111 : 32'h0, 32'h0};
        vecs[6]  = '{1'b0, 1'b1, 5'd7, 32'h22222222, 5'd7, 5'd5,
                     BYPASS ? 32'h22222222 : 32'h11111111, 32'hDEADBEEF};
        vecs[7]  = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd7, 5'd7, 32'h22222222, 32'h22222222};
        vecs[8]  = '{1'b1, 1'b1, 5'd9, 32'hABCD0123, 5'd9, 5'd7, 32'h0, 32'h22222222};
        vecs[9]  = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd9, 5'd7, 32'h0, 32'h0};
        vecs[10] = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd5, 5'd31, 32'h0, 32'h0};

        @(negedge clk);

        // Initial reset; stored state is undefined before it, so no check.
        step(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0, "init_reset");

        // Reset then read: every address reads zero on both ports.
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 1'b1, 32'h0, 32'h0, "reset_sweep");
        end

        // Table-driven directed vectors.
        for (int i = 0; i < 11; i++) begin
            step(vecs[i].rst, vecs[i].we, vecs[i].a3, vecs[i].wd, vecs[i].a1, vecs[i].a2,
                 1'b1, vecs[i].exp1, vecs[i].exp2, $sformatf("vec%0d", i));
        end

        // Full sweep: write x1..x31 in consecutive cycles, reading x0 meanwhile.
        for (int i = 1; i < 32; i++) begin
            step(1'b0, 1'b1, 5'(i), 32'h1000 + i, 5'd0, 5'd0, 1'b1, 32'h0, 32'h0, "sweep_wr");
        end
        for (int i = 0; i < 32; i++) begin
            int j;
            j = (32 - i) % 32;
            step(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(j), 1'b1,
                 (i == 0) ? 32'h0 : 32'h1000 + i, (j == 0) ? 32'h0 : 32'h1000 + j,
                 "sweep_rd");
        end

        // Randomized traffic against the model, with occasional resets and
        // deliberately frequent address collisions.
        for (int n = 0; n < 300; n++) begin
            r   = ($urandom_range(0, 31) == 0);
            w   = $urandom_range(0, 3) != 0;
            a3v = 5'($urandom_range(0, 31));
            wdv = $urandom;
            a1v = ($urandom_range(0, 3) == 0) ? a3v : 5'($urandom_range(0, 31));
            a2v = ($urandom_range(0, 3) == 0) ? a3v : 5'($urandom_range(0, 31));
            step(r, w, a3v, wdv, a1v, a2v, 1'b1,
                 model_rd(a1v, r, w, a3v, wdv), model_rd(a2v, r, w, a3v, wdv), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
